// File: rtl/key_seq_ctrl.sv
// Two-requester serial key-window reader: arbitrates in IDLE, then strobes the
// key window N times with address setup and inter-strobe gaps, returning the bits.
module key_seq_ctrl #(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned GAP_CYC   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_addr,
  input  logic [9:0]  req_nbits,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic        bus_sser_n,
  output logic        bus_ba13,
  output logic        bus_ba12,
  output logic [3:0]  bus_ba_lo,
  output logic        bus_br_w,
  input  logic        sdrd
);

  localparam int unsigned CW = 4;
  localparam int unsigned BW = 5;
  localparam int unsigned MAXBITS = 16;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitcnt;
  logic [BW-1:0] nbits_q;
  logic [3:0]    addr_q;
  logic          owner;
  logic          last_grant;
  logic          grant_pend;

  logic          gnt_vld;
  logic          gnt_idx;
  logic [BW-1:0] gnt_nbits;
  logic [BW-1:0] gnt_neff;
  logic [BW-1:0] bit_next;

  // Round-robin pick between the two requesters; the one not served last wins a tie.
  always_comb begin
    gnt_vld = |req_valid;
    gnt_idx = 1'b0;
    if (req_valid == 2'b11) gnt_idx = ~last_grant;
    else                    gnt_idx = req_valid[1];
  end

  assign gnt_nbits = gnt_idx ? req_nbits[9:5] : req_nbits[4:0];
  // Zero encodes a full 16-bit read; anything past 16 is clamped to the data width.
  assign gnt_neff  = (gnt_nbits == '0 || gnt_nbits > BW'(MAXBITS)) ? BW'(MAXBITS) : gnt_nbits;
  assign bit_next  = bitcnt + BW'(1);
  assign bus_ba13  = 1'b0;

  // Grant takes one cycle (req_ready pulse) before the address setup phase begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      nbits_q    <= '0;
      addr_q     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      grant_pend <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      busy       <= 1'b0;
      bus_sser_n <= 1'b1;
      bus_ba12   <= 1'b0;
      bus_ba_lo  <= '0;
      bus_br_w   <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (grant_pend) begin
            grant_pend <= 1'b0;
            state      <= SETUP;
            cnt        <= CW'(SETUP_CYC - 1);
            busy       <= 1'b1;
            bus_ba12   <= 1'b1;
            bus_br_w   <= 1'b1;
            bus_ba_lo  <= addr_q;
          end else if (gnt_vld) begin
            grant_pend         <= 1'b1;
            req_ready[gnt_idx] <= 1'b1;
            owner              <= gnt_idx;
            last_grant         <= gnt_idx;
            addr_q             <= gnt_idx ? req_addr[7:4] : req_addr[3:0];
            nbits_q            <= gnt_neff;
            rsp_data           <= '0;
            bitcnt             <= '0;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state      <= STROBE;
            bus_sser_n <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        STROBE: begin
          rsp_data[bitcnt[3:0]] <= sdrd;
          bitcnt                <= bit_next;
          if (bit_next == nbits_q) begin
            state            <= DONE;
            bus_sser_n       <= 1'b1;
            bus_ba12         <= 1'b0;
            bus_br_w         <= 1'b0;
            bus_ba_lo        <= '0;
            rsp_valid[owner] <= 1'b1;
          end else if (GAP_CYC == 0) begin
            state      <= STROBE;
            bus_sser_n <= 1'b0;
          end else begin
            state      <= GAP;
            bus_sser_n <= 1'b1;
            cnt        <= CW'(GAP_CYC - 1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state      <= STROBE;
            bus_sser_n <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_seq_ctrl.sv
// Scoreboard bench for key_seq_ctrl: expected grants/responses are queued at issue
// time and checked by a monitor when the DUT pulses req_ready / rsp_valid.
`timescale 1ns/1ps
module tb_key_seq_ctrl;

  localparam int SETUP = 2;
  localparam int GAP   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid;
  logic [7:0]  req_addr;
  logic [9:0]  req_nbits;
  logic        sdrd;
  logic [1:0]  req_ready, rsp_valid;
  logic [15:0] rsp_data;
  logic        busy, bus_sser_n, bus_ba13, bus_ba12, bus_br_w;
  logic [3:0]  bus_ba_lo;

  // Second instance with no inter-strobe gap
  logic [1:0]  v2, rr2, rv2;
  logic [7:0]  a2;
  logic [9:0]  n2;
  logic        s2, busy2, ss2, b13_2, b12_2, brw2;
  logic [15:0] d2;
  logic [3:0]  lo2;

  key_seq_ctrl #(.SETUP_CYC(SETUP), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_nbits(req_nbits), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .bus_sser_n(bus_sser_n), .bus_ba13(bus_ba13),
    .bus_ba12(bus_ba12), .bus_ba_lo(bus_ba_lo), .bus_br_w(bus_br_w), .sdrd(sdrd));

  key_seq_ctrl #(.SETUP_CYC(2), .GAP_CYC(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rr2),
    .req_addr(a2), .req_nbits(n2), .rsp_valid(rv2),
    .rsp_data(d2), .busy(busy2), .bus_sser_n(ss2), .bus_ba13(b13_2),
    .bus_ba12(b12_2), .bus_ba_lo(lo2), .bus_br_w(brw2), .sdrd(s2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          owner;
    int          n;
    int          lat;
    logic [3:0]  addr;
    logic [15:0] pat;
    logic [15:0] data;
  } exp_t;

  exp_t rsp_q[$];
  int   grant_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Requester descriptors and reference-model arbitration memory
  logic [3:0]  d_addr[2];
  logic [4:0]  d_nb[2];
  logic [15:0] d_pat[2];
  bit          pend[2];
  int          m_lg = 1;
  int          last_wait;
  int          t_ready, t_rsp;
  int          sidx;
  logic [15:0] cur_pat;
  logic [3:0]  cur_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_n(input logic [4:0] nb);
    return (nb == 5'd0) ? 16 : int'(nb);
  endfunction

  task automatic push_exp(input int g);
    exp_t e;
    e.owner = g;
    e.n     = eff_n(d_nb[g]);
    e.lat   = SETUP + e.n + (e.n - 1) * GAP + 1;
    e.addr  = d_addr[g];
    e.pat   = d_pat[g];
    e.data  = 16'(32'(d_pat[g]) & ((32'd1 << e.n) - 32'd1));
    grant_q.push_back(g);
    rsp_q.push_back(e);
    m_lg = g;
  endtask

  task automatic drive_reqs();
    req_valid = {pend[1], pend[0]};
    req_addr  = {d_addr[1], d_addr[0]};
    req_nbits = {d_nb[1], d_nb[0]};
  endtask

  task automatic rand_desc(input int g);
    d_addr[g] = 4'($urandom_range(0, 15));
    d_nb[g]   = 5'($urandom_range(0, 16));
    d_pat[g]  = 16'($urandom);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (req_ready != 2'b00) begin
        ok = 1'b1;
        last_wait = i + 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL grant_timeout: no req_ready within 300 cycles, valid=%b", req_valid);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rsp_q.size() == 0 && grant_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: %0d responses still outstanding", rsp_q.size());
    end
  endtask

  // Issue the pending requests; winners are predicted from the arbitration rule.
  task automatic run(input int refills);
    bit ok;
    int g;
    int r;
    r = refills;
    drive_reqs();
    while (pend[0] || pend[1]) begin
      if (pend[0] && pend[1]) g = 1 - m_lg;
      else                    g = pend[1] ? 1 : 0;
      push_exp(g);
      wait_grant(ok);
      if (!ok) break;
      if (r > 0) begin
        r--;
        rand_desc(g);
      end else begin
        pend[g] = 1'b0;
      end
      drive_reqs();
    end
    drain();
  endtask

  // Monitor: grant, strobe-phase bus checks plus sdrd feed, and response scoreboard
  always @(negedge clk) begin
    exp_t e;
    int   g;
    if (rst_n) begin
      if (req_ready != 2'b00) begin
        if (grant_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_grant: req_ready=%b", req_ready);
        end else begin
          g = grant_q.pop_front();
          check("grant_index", 32'(req_ready), 32'(2'b01 << g));
          check("ready_busy_low", 32'(busy), 32'd0);
          t_ready = cyc;
          sidx    = 0;
          cur_pat  = (rsp_q.size() != 0) ? rsp_q[0].pat  : 16'h0;
          cur_addr = (rsp_q.size() != 0) ? rsp_q[0].addr : 4'h0;
        end
      end
      if (!bus_sser_n) begin
        check("strobe_ba_lo", 32'(bus_ba_lo), 32'(cur_addr));
        check("strobe_ba12_brw", 32'({bus_ba13, bus_ba12, bus_br_w}), 32'b011);
        sdrd = (sidx < 16) ? cur_pat[sidx] : 1'b0;
        sidx++;
      end
      if (rsp_valid != 2'b00) begin
        t_rsp = cyc;
        if (rsp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rsp: rsp_valid=%b", rsp_valid);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_owner", 32'(rsp_valid), 32'(2'b01 << e.owner));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_latency", 32'(cyc - t_ready), 32'(e.lat));
          check("strobe_count", 32'(sidx), 32'(e.n));
          check("done_bus_idle", 32'({bus_sser_n, bus_ba12, bus_br_w, bus_ba_lo}), 32'h40);
        end
      end
    end
  end

  initial begin
    bit          ok;
    int          t0, cnt, runlen, maxrun;
    logic [15:0] pat2;
    req_valid = '0; req_addr = '0; req_nbits = '0; sdrd = 1'b0;
    v2 = '0; a2 = '0; n2 = '0; s2 = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready_valid_busy", 32'({req_ready, rsp_valid, busy}), 32'd0);
    check("rst_bus", 32'({bus_sser_n, bus_ba13, bus_ba12, bus_br_w, bus_ba_lo}), 32'h80);
    check("rst_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;

    // Both requesters continuously valid: alternate, requester 0 first
    rand_desc(0); rand_desc(1);
    pend[0] = 1'b1; pend[1] = 1'b1;
    run(2);

    // Single transfer with defaults, pattern 1,0,1,1
    d_addr[0] = 4'hA; d_nb[0] = 5'd4; d_pat[0] = 16'h000D;
    pend[0] = 1'b1;
    run(0);

    // Full 16-bit read via nbits=0
    d_addr[0] = 4'h3; d_nb[0] = 5'd0; d_pat[0] = 16'hC35A;
    pend[0] = 1'b1;
    run(0);

    // Requester 1 arrives while requester 0 is busy
    rand_desc(0); rand_desc(1);
    d_nb[0] = 5'd3;
    pend[0] = 1'b1;
    drive_reqs();
    push_exp(0);
    wait_grant(ok);
    pend[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    pend[1] = 1'b1;
    drive_reqs();
    push_exp(1);
    wait_grant(ok);
    check("r1_waits_for_done", 32'(cyc > t_rsp && rsp_q.size() == 1), 32'd1);
    pend[1] = 1'b0;
    drive_reqs();
    drain();

    // Randomized traffic
    for (int k = 0; k < 14; k++) begin
      int m;
      m = $urandom_range(1, 3);
      rand_desc(0); rand_desc(1);
      pend[0] = m[0]; pend[1] = m[1];
      run(int'($urandom_range(0, 2)));
    end

    // Reset during the second strobe aborts with no response
    d_addr[0] = 4'h6; d_nb[0] = 5'd4; d_pat[0] = 16'h00FF;
    pend[0] = 1'b1;
    drive_reqs();
    push_exp(0);
    wait_grant(ok);
    pend[0] = 1'b0;
    drive_reqs();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (!bus_sser_n && sidx == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("reached_second_strobe", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_sser_busy", 32'({bus_sser_n, busy}), 32'b10);
    check("midrst_valid_ready", 32'({rsp_valid, req_ready}), 32'd0);
    check("midrst_data", 32'(rsp_data), 32'd0);
    rsp_q.delete();
    grant_q.delete();
    m_lg = 1;
    repeat (2) @(negedge clk);
    #2;
    rand_desc(1);
    pend[1] = 1'b1;
    drive_reqs();
    push_exp(1);
    rst_n = 1'b1;
    wait_grant(ok);
    check("grant_after_reset", 32'(last_wait), 32'd1);
    pend[1] = 1'b0;
    drive_reqs();
    drain();

    // Zero-gap instance: three back-to-back strobes
    pat2 = 16'hFFFB;
    a2 = 8'h05; n2 = 10'd3;
    @(negedge clk);
    v2 = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (rr2 != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    check("g0_grant", 32'({ok, rr2}), 32'b101);
    t0 = cyc; v2 = 2'b00; cnt = 0; runlen = 0; maxrun = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!ss2) begin
        check("g0_ba_lo", 32'(lo2), 32'h5);
        s2 = (cnt < 16) ? pat2[cnt] : 1'b0;
        cnt++;
        runlen++;
        if (runlen > maxrun) maxrun = runlen;
      end else begin
        runlen = 0;
      end
      if (rv2 != 2'b00) begin
        ok = 1'b1;
        check("g0_latency", 32'(cyc - t0), 32'd6);
        check("g0_data", 32'(d2), 32'h0003);
        check("g0_owner", 32'(rv2), 32'b01);
        break;
      end
    end
    check("g0_completed", 32'(ok), 32'd1);
    check("g0_strobes", 32'({cnt[7:0], maxrun[7:0]}), 32'h0303);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/key_seq_ctrl.md
KEY_SEQ_CTRL -- requirements
Module: key_seq_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: address-setup cycles before the first strobe, legal range 1..15.
REQ-002 SHALL have parameter GAP_CYC, default 1: idle cycles between strobes, legal range 0..15.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge; the only clock in the block.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 2: request from requester i on bit i.
REQ-006 SHALL have port req_ready, output, 2: one-cycle accept pulse to the granted requester.
REQ-007 SHALL have port req_addr, input, 8: nibble for BA7..BA4; [3:0] is requester 0, [7:4] is requester 1.
REQ-008 SHALL have port req_nbits, input, 10: bit count 1..16 per requester, 0 meaning 16; [4:0] is requester 0, [9:5] is requester 1.
REQ-009 SHALL have port rsp_valid, output, 2: one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port rsp_data, output, 16: collected bits, LSB first, zero-extended.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-012 SHALL have port bus_sser_n, output, 1: key-window select, active-low.
REQ-013 SHALL have ports bus_ba13 and bus_ba12, outputs, 1 each: window decode lines.
REQ-014 SHALL have port bus_ba_lo, output, 4: drives BA7..BA4.
REQ-015 SHALL have port bus_br_w, output, 1: high means read.
REQ-016 SHALL have port sdrd, input, 1: serial data returned from the key window.

Function
REQ-017 SHALL implement the states IDLE, SETUP, STROBE, GAP and DONE.
REQ-018 In IDLE, SHALL drive bus_sser_n=1, bus_ba13=0, bus_ba12=0, bus_br_w=0 and bus_ba_lo=0.
REQ-019 Arbitration SHALL happen only in IDLE:
- a single valid requester is granted;
- when both are valid, the requester not granted last wins;
- the last-grant register resets to 1, so requester 0 wins the first tie.
REQ-020 On grant, SHALL pulse req_ready[g] for one cycle, latch addr and nbits of requester g, clear the shift register and bit count, and go to SETUP.
REQ-021 In SETUP, STROBE and GAP, SHALL drive bus_ba13=0, bus_ba12=1, bus_br_w=1 and bus_ba_lo=latched addr.
REQ-022 SETUP SHALL last SETUP_CYC cycles with bus_sser_n=1, then go to STROBE.
REQ-023 STROBE SHALL last exactly one cycle with bus_sser_n=0.
REQ-024 The edge ending STROBE SHALL capture sdrd into data[bitcnt] and increment bitcnt.
REQ-025 After STROBE:
- if bitcnt equals nbits, go to DONE;
- else if GAP_CYC=0, go to STROBE again (bus_sser_n stays low);
- else go to GAP for GAP_CYC cycles with bus_sser_n=1, then STROBE.
REQ-026 DONE SHALL last one cycle: bus lines return to IDLE values, rsp_valid[g]=1, rsp_data holds the bits, then go to IDLE.
REQ-027 rsp_data SHALL hold its value until the next grant.
REQ-028 Latency from the req_ready pulse (cycle 0) to rsp_valid SHALL be SETUP_CYC + N + (N-1)*GAP_CYC + 1 cycles, where N is the effective bit count.
REQ-029 Requests arriving while busy SHALL be held off (req_ready=0), with no loss and no queue beyond the input valid.
REQ-030 A requester dropping req_valid before its grant SHALL NOT be granted.
REQ-031 A requester dropping req_valid after its grant SHALL NOT affect the transfer in progress.
REQ-032 The bit counter SHALL be 5 bits wide.
REQ-033 Bits above N in rsp_data SHALL be 0.

Reset
REQ-034 rst_n low SHALL immediately force:
- state IDLE;
- all bus lines to their IDLE values, including bus_sser_n=1;
- req_ready=0, rsp_valid=0, busy=0;
- rsp_data=0, bit count 0;
- last-grant=1.
REQ-035 Reset in the middle of a transfer SHALL abort it with no rsp_valid pulse; bus_sser_n SHALL never glitch low during or after reset.
REQ-036 After rst_n deasserts, the first request SHALL be accepted in the next cycle.

Verification
REQ-037 Single transfer with defaults: req0, addr 0xA, nbits 4, sdrd pattern 1,0,1,1 -> rsp_valid[0] at cycle 10, rsp_data=0x000D, four bus_sser_n low pulses with bus_ba_lo=0xA.
REQ-038 nbits=0 -> 16 strobes, rsp_data equals the 16-bit sdrd pattern (e.g. 0xC35A), latency 2+16+15+1=34.
REQ-039 Both requesters valid continuously -> grants alternate 0,1,0,1, and each rsp_valid bit matches its grant.
REQ-040 GAP_CYC=0, nbits 3 -> bus_sser_n low for 3 consecutive cycles, latency 2+3+1=6.
REQ-041 rst_n low during the second strobe -> bus_sser_n=1 and busy=0 at once, no rsp_valid; the next request completes normally.
REQ-042 req1 asserted while req0 is busy -> req_ready[1] only after the DONE cycle of req0, and bus_ba_lo switches only after that grant.
